// File: rtl/my_mem_arbiter.sv
// my_mem_arbiter: shares the single memory port between the CPU data port and
// a read-only video scanout requester. The CPU has priority. The video
// requester wins anyway once it has been denied MAX_WAIT cycles in a row.
// Read data is registered and returned one cycle after the grant, together
// with a one-cycle valid pulse.
module my_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 3   // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU data port
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  // video scanout port (screen-relative offsets only)
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  // memory port
  output logic [14:0] mem_addr,
  output logic [15:0] mem_in,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  localparam logic [3:0] WAIT_CAP = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        vid_rvalid_q, vid_rvalid_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;
  logic        cpu_win, vid_win;

  // Grant decision; nobody owns the port while reset is held low.
  always_comb begin
    cpu_win = 1'b0;
    vid_win = 1'b0;
    if (rst_n) begin
      if (vid_req && (!cpu_req || (wait_cnt_q == WAIT_CAP))) begin
        vid_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign vid_gnt = vid_win;

  // Memory port mux; video is pinned into the screen window (0x4000-0x5FFF).
  always_comb begin
    mem_addr = '0;
    mem_in   = '0;
    mem_load = 1'b0;
    if (cpu_win) begin
      mem_addr = cpu_addr;
      mem_in   = cpu_wdata;
      mem_load = cpu_we;
    end else if (vid_win) begin
      mem_addr = {2'b10, vid_addr};
    end
  end

  // Next-state: starvation counter, read-data capture and valid pulses.
  always_comb begin
    wait_cnt_d   = 4'd0;
    cpu_rvalid_d = cpu_win && !cpu_we;
    vid_rvalid_d = vid_win;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;

    if (vid_req && !vid_win) begin
      wait_cnt_d = (wait_cnt_q >= WAIT_CAP) ? WAIT_CAP : (wait_cnt_q + 4'd1);
    end

    if (cpu_rvalid_d) begin
      cpu_rdata_d = mem_out;
    end
    if (vid_rvalid_d) begin
      vid_rdata_d = mem_out;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q   <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 16'h0000;
      vid_rdata_q  <= 16'h0000;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rdata_q;

endmodule
